// File: rtl/host_cmd_bridge_pkg.sv
// Shared codes for the host command bridge: memory-op encodings, command opcodes, FSM states.
// No logic beyond a byte-select helper.
package host_cmd_bridge_pkg;

    typedef logic [63:0] word_t;

    localparam logic [1:0] MEM_OP_NOP   = 2'd0;
    localparam logic [1:0] MEM_OP_READ  = 2'd1;
    localparam logic [1:0] MEM_OP_WRITE = 2'd2;

    localparam logic [7:0] OPC_READ  = 8'h01;
    localparam logic [7:0] OPC_WRITE = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    function automatic logic [7:0] byte_at(input word_t word, input logic [2:0] idx);
        return word[8*idx +: 8];
    endfunction

endpackage

// File: rtl/byte_shift_le.sv
// 8-byte little-endian word register: byte-wise assembly at an index, or whole-word load for readout.
// One-cycle write latency; no flow control, the owner sequences i_idx.
module byte_shift_le
    import host_cmd_bridge_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  word_t      i_load_word,
    input  logic       i_wr,
    input  logic [2:0] i_idx,
    input  logic [7:0] i_byte,
    output word_t      o_word
);

    word_t word_q, word_d;

    always_comb begin
        word_d = word_q;
        if (i_load) begin
            word_d = i_load_word;
        end else if (i_wr) begin
            word_d[8*i_idx +: 8] = i_byte;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign o_word = word_q;

endmodule

// File: rtl/host_cmd_bridge.sv
// Byte-stream host command bridge: framed read/write commands to a single memory-op port, bytes back out.
// One-cycle op strobe after the last command byte; responses held until i_tx_rdy, rx bytes dropped while busy.
module host_cmd_bridge
    import host_cmd_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  ACK_BYTE       = 8'hAA,
    parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_rdy,
    output logic [1:0]  o_mem_op,
    output logic [63:0] o_mem_addr,
    output logic [63:0] o_mem_data,
    input  logic [63:0] i_mem_data,
    input  logic        i_mem_op_pending,
    output logic        o_busy,
    output logic        o_overrun
);

    localparam int unsigned   TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          is_wr_q, is_wr_d;
    logic          resp_multi_q, resp_multi_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          overrun_q, overrun_d;
    logic          addr_wr, data_wr, rdata_ld;
    word_t         addr_word, data_word, rdata_word;

    byte_shift_le u_addr (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (1'b0),
        .i_load_word ('0),
        .i_wr        (addr_wr),
        .i_idx       (cnt_q),
        .i_byte      (i_rx_data),
        .o_word      (addr_word)
    );

    byte_shift_le u_wdata (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (1'b0),
        .i_load_word ('0),
        .i_wr        (data_wr),
        .i_idx       (cnt_q),
        .i_byte      (i_rx_data),
        .o_word      (data_word)
    );

    byte_shift_le u_rdata (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (rdata_ld),
        .i_load_word (i_mem_data),
        .i_wr        (1'b0),
        .i_idx       (3'd0),
        .i_byte      (8'h00),
        .o_word      (rdata_word)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tmo_q        <= '0;
            is_wr_q      <= 1'b0;
            resp_multi_q <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            is_wr_q      <= is_wr_d;
            resp_multi_q <= resp_multi_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tmo_d        = '0;
        is_wr_d      = is_wr_q;
        resp_multi_d = resp_multi_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        overrun_d    = overrun_q;
        addr_wr      = 1'b0;
        data_wr      = 1'b0;
        rdata_ld     = 1'b0;
        o_mem_op     = MEM_OP_NOP;

        unique case (state_q)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    cnt_d = '0;
                    if (i_rx_data == OPC_READ || i_rx_data == OPC_WRITE) begin
                        is_wr_d = (i_rx_data == OPC_WRITE);
                        state_d = ST_ADDR;
                    end else begin
                        resp_multi_d = 1'b0;
                        tx_data_d    = ERR_BYTE;
                        tx_valid_d   = 1'b1;
                        state_d      = ST_RESP;
                    end
                end
            end
            ST_ADDR, ST_DATA: begin
                // A strobe wins over an expiring timeout in the same cycle.
                if (i_rx_valid) begin
                    addr_wr = (state_q == ST_ADDR);
                    data_wr = (state_q == ST_DATA);
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = (state_q == ST_ADDR && is_wr_q) ? ST_DATA : ST_ISSUE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_ISSUE: begin
                o_mem_op = is_wr_q ? MEM_OP_WRITE : MEM_OP_READ;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (!i_mem_op_pending) begin
                    cnt_d        = '0;
                    rdata_ld     = !is_wr_q;
                    resp_multi_d = !is_wr_q;
                    tx_data_d    = is_wr_q ? ACK_BYTE : i_mem_data[7:0];
                    tx_valid_d   = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (tx_valid_q && i_tx_rdy) begin
                    if (!resp_multi_q || cnt_q == 3'd7) begin
                        cnt_d      = '0;
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d     = cnt_q + 3'd1;
                        tx_data_d = byte_at(rdata_word, cnt_q + 3'd1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_rx_valid && (state_q == ST_ISSUE || state_q == ST_WAIT || state_q == ST_RESP)) begin
            overrun_d = 1'b1;
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_mem_addr = addr_word;
    assign o_mem_data = data_word;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_host_cmd_bridge.sv
// Directed bench for host_cmd_bridge: write, read with wait, register read, bad opcode, timeout, overrun, reset.
module tb_host_cmd_bridge;

    localparam int unsigned TMO   = 1024;
    localparam int          LIMIT = 300;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_rdy;
    logic [1:0]  o_mem_op;
    logic [63:0] o_mem_addr;
    logic [63:0] o_mem_data;
    logic [63:0] i_mem_data;
    logic        i_mem_op_pending;
    logic        o_busy;
    logic        o_overrun;

    int          n_checks = 0;
    int          n_errs   = 0;
    int          op_count = 0;
    logic [1:0]  last_op   = '0;
    logic [63:0] last_addr = '0;
    logic [63:0] last_data = '0;
    logic [7:0]  txq[$];

    host_cmd_bridge #(
        .TIMEOUT_CYCLES (TMO),
        .ACK_BYTE       (8'hAA),
        .ERR_BYTE       (8'hEE)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_rx_data        (i_rx_data),
        .i_rx_valid       (i_rx_valid),
        .o_tx_data        (o_tx_data),
        .o_tx_valid       (o_tx_valid),
        .i_tx_rdy         (i_tx_rdy),
        .o_mem_op         (o_mem_op),
        .o_mem_addr       (o_mem_addr),
        .o_mem_data       (o_mem_data),
        .i_mem_data       (i_mem_data),
        .i_mem_op_pending (i_mem_op_pending),
        .o_busy           (o_busy),
        .o_overrun        (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    // Record memory ops and accepted tx bytes mid-cycle, clear of both clock edges.
    always begin
        @(negedge i_clk);
        #1;
        if (o_mem_op != 2'd0) begin
            op_count++;
            last_op   = o_mem_op;
            last_addr = o_mem_addr;
            last_data = o_mem_data;
        end
        if (o_tx_valid && i_tx_rdy) txq.push_back(o_tx_data);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
    endtask

    task automatic rx_idle();
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        i_rx_data  = '0;
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int i = 0; i < 8; i++) send(w[8*i +: 8]);
    endtask

    task automatic expect_tx(input string tag, input int n, input logic [63:0] w);
        int         cyc;
        logic [7:0] g;
        cyc = 0;
        while (txq.size() < n && cyc < LIMIT) begin
            @(negedge i_clk);
            cyc++;
        end
        repeat (3) @(negedge i_clk);
        check({tag, " count"}, 64'(txq.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            g = 'x;
            if (i < txq.size()) g = txq[i];
            check($sformatf("%s byte%0d", tag, i), 64'(g), 64'(w[8*i +: 8]));
        end
    endtask

    task automatic wait_op(input int base);
        int cyc;
        cyc = 0;
        while (op_count == base && cyc < LIMIT) begin
            @(negedge i_clk);
            cyc++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cyc;
        i_rst            = 1'b1;
        i_rx_valid       = 1'b0;
        i_rx_data        = '0;
        i_tx_rdy         = 1'b1;
        i_mem_data       = '0;
        i_mem_op_pending = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst busy",    64'(o_busy),     64'd0);
        check("rst txvalid", 64'(o_tx_valid), 64'd0);
        check("rst txdata",  64'(o_tx_data),  64'd0);
        check("rst memop",   64'(o_mem_op),   64'd0);
        check("rst addr",    o_mem_addr,      64'd0);
        check("rst data",    o_mem_data,      64'd0);
        check("rst overrun", 64'(o_overrun),  64'd0);
        i_rst = 1'b0;

        // Write 0xDEADBEEF to 0x10, expect one op cycle and a single ACK.
        txq.delete();
        base = op_count;
        send(8'h02);
        send_word(64'h10);
        send_word(64'hDEADBEEF);
        rx_idle();
        expect_tx("wr ack", 1, 64'hAA);
        check("wr op count", 64'(op_count - base), 64'd1);
        check("wr op",       64'(last_op),         64'd2);
        check("wr addr",     last_addr,            64'h10);
        check("wr data",     last_data,            64'hDEADBEEF);
        check("wr idle",     64'(o_busy),          64'd0);

        // Read with pending held; junk on i_mem_data until pending drops.
        txq.delete();
        base             = op_count;
        i_mem_op_pending = 1'b1;
        i_mem_data       = '1;
        send(8'h01);
        send_word(64'h20);
        rx_idle();
        wait_op(base);
        check("rd op count", 64'(op_count - base), 64'd1);
        check("rd op",       64'(last_op),         64'd1);
        check("rd addr",     last_addr,            64'h20);
        repeat (2) @(negedge i_clk);
        check("rd wait busy", 64'(o_busy),     64'd1);
        check("rd wait notx", 64'(o_tx_valid), 64'd0);
        i_mem_op_pending = 1'b0;
        i_mem_data       = 64'h0123456789ABCDEF;
        expect_tx("rd pend", 8, 64'h0123456789ABCDEF);

        // Zero-latency register read: data valid only in the first WAIT cycle.
        txq.delete();
        base       = op_count;
        i_mem_data = '0;
        send(8'h01);
        send_word(64'h8000000000000001);
        rx_idle();
        check("regrd op",   64'(o_mem_op), 64'd1);
        check("regrd addr", o_mem_addr,    64'h8000000000000001);
        @(negedge i_clk);
        i_mem_data = 64'h1;
        @(negedge i_clk);
        i_mem_data = 64'h0;
        expect_tx("regrd", 8, 64'h1);
        check("regrd op count", 64'(op_count - base), 64'd1);

        // Unknown opcode with the sink stalled.
        txq.delete();
        base     = op_count;
        i_tx_rdy = 1'b0;
        send(8'h55);
        rx_idle();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("err hold valid%0d", i), 64'(o_tx_valid), 64'd1);
            check($sformatf("err hold data%0d", i),  64'(o_tx_data),  64'hEE);
            @(negedge i_clk);
        end
        i_tx_rdy = 1'b1;
        expect_tx("err", 1, 64'hEE);
        check("err no op",  64'(op_count - base), 64'd0);
        check("err no ovr", 64'(o_overrun),       64'd0);

        // Partial command then silence: abort exactly TMO idle cycles after the last byte.
        txq.delete();
        base = op_count;
        send(8'h01);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        rx_idle();
        repeat (TMO - 1) @(negedge i_clk);
        check("tmo still busy", 64'(o_busy), 64'd1);
        @(negedge i_clk);
        check("tmo aborted",  64'(o_busy),            64'd0);
        check("tmo no op",    64'(op_count - base),   64'd0);
        check("tmo no tx",    64'(txq.size()),        64'd0);

        // Byte landing on the expiry cycle is kept; a strobe during WAIT sets overrun.
        txq.delete();
        base             = op_count;
        i_mem_op_pending = 1'b1;
        send(8'h01);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        rx_idle();
        repeat (TMO - 2) @(negedge i_clk);
        send(8'h44);
        send(8'h55);
        send(8'h66);
        send(8'h77);
        send(8'h88);
        rx_idle();
        wait_op(base);
        check("edge op count", 64'(op_count - base), 64'd1);
        check("edge addr",     last_addr,            64'h8877665544332211);
        check("ovr before",    64'(o_overrun),       64'd0);
        send(8'h5A);
        rx_idle();
        check("ovr set",       64'(o_overrun),       64'd1);
        i_mem_op_pending = 1'b0;
        i_mem_data       = 64'hCAFEF00D12345678;
        expect_tx("edge rd", 8, 64'hCAFEF00D12345678);
        check("ovr sticky",    64'(o_overrun),       64'd1);

        // Reset while the third response byte is offered.
        txq.delete();
        base       = op_count;
        i_tx_rdy   = 1'b0;
        i_mem_data = 64'h0123456789ABCDEF;
        send(8'h01);
        send_word(64'h30);
        rx_idle();
        cyc = 0;
        while (!o_tx_valid && cyc < LIMIT) begin
            @(negedge i_clk);
            cyc++;
        end
        check("rstr resp valid", 64'(o_tx_valid), 64'd1);
        i_tx_rdy = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst    = 1'b1;
        i_tx_rdy = 1'b0;
        @(negedge i_clk);
        check("rstr txvalid", 64'(o_tx_valid), 64'd0);
        check("rstr txdata",  64'(o_tx_data),  64'd0);
        check("rstr busy",    64'(o_busy),     64'd0);
        check("rstr overrun", 64'(o_overrun),  64'd0);
        i_rst    = 1'b0;
        i_tx_rdy = 1'b1;
        repeat (4) @(negedge i_clk);
        check("rstr accepted", 64'(txq.size()),     64'd2);
        check("rstr byte0",    64'(txq[0]),         64'hEF);
        check("rstr byte1",    64'(txq[1]),         64'hCD);
        check("rstr no op",    64'(op_count - base), 64'd1);

        txq.delete();
        base = op_count;
        send(8'h02);
        send_word(64'h40);
        send_word(64'h55);
        rx_idle();
        expect_tx("post wr", 1, 64'hAA);
        check("post op count", 64'(op_count - base), 64'd1);
        check("post op",       64'(last_op),         64'd2);
        check("post addr",     last_addr,            64'h40);
        check("post data",     last_data,            64'h55);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/host_cmd_bridge.md
HOST_CMD_BRIDGE -- requirements
Module: host_cmd_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, max idle cycles between bytes of one command.
REQ-002 SHALL have parameter ACK_BYTE, default 8'hAA, write-completion response byte.
REQ-003 SHALL have parameter ERR_BYTE, default 8'hEE, unknown-opcode response byte.
REQ-004 i_clk  in  1  clock, all logic on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_rx_data  in  8  received byte.
REQ-007 i_rx_valid  in  1  one-cycle strobe, i_rx_data valid.
REQ-008 o_tx_data  out  8  response byte.
REQ-009 o_tx_valid  out  1  response byte offered.
REQ-010 i_tx_rdy  in  1  sink accepts; transfer when o_tx_valid && i_tx_rdy.
REQ-011 o_mem_op  out  2  0 NOP, 1 READ, 2 WRITE; drives downstream memory-op port.
REQ-012 o_mem_addr  out  64  operation address.
REQ-013 o_mem_data  out  64  write data.
REQ-014 i_mem_data  in  64  read data from downstream.
REQ-015 i_mem_op_pending  in  1  downstream busy.
REQ-016 o_busy  out  1  high in every state except IDLE.
REQ-017 o_overrun  out  1  sticky: a byte arrived while it could not be accepted.

Function
REQ-018 Command framing: opcode byte (8'h01 read, 8'h02 write), 8 address bytes LSB first, then for write 8 data bytes LSB first.
REQ-019 States: IDLE, ADDR, DATA, ISSUE, WAIT, RESP.
REQ-020 IDLE: on i_rx_valid, opcode 01/02 -> ADDR with byte counter 0; any other value -> RESP loaded with single byte ERR_BYTE.
REQ-021 ADDR: each strobe shifts the byte into addr[8*cnt +: 8]; the 8th byte -> DATA if write, else ISSUE.
REQ-022 DATA: same assembly into the write-data register; the 8th byte -> ISSUE.
REQ-023 ISSUE: o_mem_op = opcode for exactly one cycle with address/data stable, then -> WAIT; o_mem_op SHALL be NOP in all other cycles.
REQ-024 WAIT: from the first WAIT cycle on, the first cycle with i_mem_op_pending==0 captures i_mem_data (read) and -> RESP; wait is unbounded.
REQ-025 Result: the first eligible WAIT cycle is one cycle after ISSUE, so a zero-latency register read (data valid, pending never raised) is captured there.
REQ-026 RESP read: send 8 bytes of the captured data LSB first.
REQ-027 RESP write: send ACK_BYTE once.
REQ-028 RESP handshake: o_tx_valid held with stable o_tx_data until accepted; the next byte is offered the following cycle; after the last accept -> IDLE.
REQ-029 Timeout: in ADDR/DATA, a counter is cleared on each strobe; reaching TIMEOUT_CYCLES without a strobe -> IDLE, partial command discarded, no response.
REQ-030 A strobe on the same cycle the timeout expires SHALL be accepted and clear the counter, not abort.
REQ-031 Strobes in ISSUE, WAIT or RESP are dropped and set o_overrun.
REQ-032 o_overrun clears only on reset.
REQ-033 The byte counter is 3 bits; wrap 7->0 coincides with the state change.

Reset
REQ-034 Reset SHALL set: state IDLE; o_mem_op 0; o_mem_addr 0; o_mem_data 0; o_tx_valid 0; o_tx_data 0; o_overrun 0; counters 0.
REQ-035 Reset mid-command or mid-response SHALL abort immediately: no further o_mem_op, no partial byte retained.

Structure
REQ-036 Shared package SHALL hold the MEM_OP_NOP/READ/WRITE codes, the opcode byte constants and the state encoding.
REQ-037 One sub-module is natural: byte_shift_le, an 8-byte LSB-first assembler/serializer used for both address/data receive and response transmit.

Verification
REQ-038 Write: bytes 02, 10 00 00 00 00 00 00 00, EF BE AD DE 00 00 00 00 -> one cycle o_mem_op=2, addr 0x10, data 0xDEADBEEF; then a single AA byte.
REQ-039 Read with pending held 2 cycles, i_mem_data=0x0123456789ABCDEF -> tx bytes EF CD AB 89 67 45 23 01.
REQ-040 Register read: addr 0x8000000000000001, pending never raised, data 1 in the cycle after ISSUE -> tx 01 then seven 00.
REQ-041 Opcode 0x55 -> tx EE, no o_mem_op; i_tx_rdy low 5 cycles -> o_tx_data held stable.
REQ-042 Opcode 01 plus 3 address bytes, then silence for TIMEOUT_CYCLES -> IDLE, no op issued; a strobe during WAIT -> o_overrun=1.
REQ-043 Reset asserted during RESP byte 3 -> o_tx_valid 0 next cycle; a new command afterwards completes normally.
